// File: rtl/if_id_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue_if
// Brief    : Fetch-side and decode-side handshake bundle for if_id_queue.
// Revision : 1.0
// ============================================================================
interface if_id_queue_if #(
    parameter int unsigned DEPTH = 2
);
    logic                     flush;
    logic                     in_valid;
    logic [31:0]              in_pc;
    logic [31:0]              in_instr;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_pc;
    logic [31:0]              out_instr;
    logic [31:0]              out_pc4;
    logic [5:0]               out_op;
    logic [4:0]               out_rs;
    logic [4:0]               out_rt;
    logic [4:0]               out_rd;
    logic [4:0]               out_shamt;
    logic [5:0]               out_funct;
    logic [15:0]              out_imm16;
    logic [25:0]              out_imm26;
    logic                     out_misalign;
    logic                     out_range_err;
    logic [$clog2(DEPTH):0]   occupancy;

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_pc4,
               out_op, out_rs, out_rt, out_rd, out_shamt, out_funct,
               out_imm16, out_imm26, out_misalign, out_range_err, occupancy
    );

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_pc4,
               out_op, out_rs, out_rt, out_rd, out_shamt, out_funct,
               out_imm16, out_imm26, out_misalign, out_range_err, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Brief    : In-order fetch->decode FIFO with pre-sliced fields and flush.
// Revision : 1.0
// ============================================================================
module if_id_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] PC_BASE   = 32'h00003000,
    parameter int unsigned ROM_WORDS = 4096
) (
    input  wire logic       clk,
    input  wire logic       reset,
    if_id_queue_if.slave    bus
);
    localparam int unsigned     c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     c_CW   = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
    localparam logic [32:0]     c_LO   = {1'b0, PC_BASE};
    localparam logic [32:0]     c_HI   = c_LO + (33'(ROM_WORDS) << 2);

    logic [31:0]     r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];
    logic            r_mis_mem   [DEPTH];
    logic            r_rerr_mem  [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_in_mis;
    logic            w_in_rerr;
    logic [32:0]     w_in_pc33;
    logic [31:0]     w_head_pc;
    logic [31:0]     w_head_instr;
    logic            w_head_mis;
    logic            w_head_rerr;

    assign w_in_ready  = reset & (r_count != c_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
    assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

    // 33-bit compare keeps PC_BASE + 4*ROM_WORDS from wrapping at the top of memory
    assign w_in_pc33 = {1'b0, bus.in_pc};
    assign w_in_mis  = (bus.in_pc[1:0] != 2'b00);
    assign w_in_rerr = (w_in_pc33 < c_LO) | (w_in_pc33 >= c_HI);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]    <= bus.in_pc;
            r_instr_mem[r_wptr] <= bus.in_instr;
            r_mis_mem[r_wptr]   <= w_in_mis;
            r_rerr_mem[r_wptr]  <= w_in_rerr;
        end
    end

    // Empty queue presents a nop at pc 0 with clean error flags
    assign w_head_pc    = w_out_valid ? r_pc_mem[r_rptr]    : 32'h0;
    assign w_head_instr = w_out_valid ? r_instr_mem[r_rptr] : 32'h0;
    assign w_head_mis   = w_out_valid & r_mis_mem[r_rptr];
    assign w_head_rerr  = w_out_valid & r_rerr_mem[r_rptr];

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_pc        = w_head_pc;
    assign bus.out_instr     = w_head_instr;
    assign bus.out_pc4       = w_head_pc + 32'd4;
    assign bus.out_op        = w_head_instr[31:26];
    assign bus.out_rs        = w_head_instr[25:21];
    assign bus.out_rt        = w_head_instr[20:16];
    assign bus.out_rd        = w_head_instr[15:11];
    assign bus.out_shamt     = w_head_instr[10:6];
    assign bus.out_funct     = w_head_instr[5:0];
    assign bus.out_imm16     = w_head_instr[15:0];
    assign bus.out_imm26     = w_head_instr[25:0];
    assign bus.out_misalign  = w_head_mis;
    assign bus.out_range_err = w_head_rerr;
    assign bus.occupancy     = r_count;
endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_queue
// Brief    : Directed + random bench for if_id_queue against a queue model.
// Revision : 1.0
// ============================================================================
module tb_if_id_queue;
    localparam int unsigned c_DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    ent_t mq[$];

    if_id_queue_if #(.DEPTH(c_DEPTH)) bus ();

    if_id_queue #(
        .DEPTH     (c_DEPTH),
        .PC_BASE   (32'h00003000),
        .ROM_WORDS (4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit          v;
        bit          rdy;
        logic [31:0] pc;
        logic [31:0] ins;
        longint      p;
        bit          mis;
        bit          rerr;
        v    = (mq.size() != 0);
        rdy  = (reset === 1'b1) && (mq.size() < c_DEPTH);
        pc   = v ? mq[0].pc : 32'h0;
        ins  = v ? mq[0].instr : 32'h0;
        p    = longint'(pc);
        mis  = v && (p % 4 != 0);
        rerr = v && ((p < 'h3000) || (p >= 'h3000 + 4 * 4096));
        chk("in_ready",  32'(bus.in_ready),      32'(rdy));
        chk("out_valid", 32'(bus.out_valid),     32'(v));
        chk("occupancy", 32'(bus.occupancy),     32'(mq.size()));
        chk("out_pc",    bus.out_pc,             pc);
        chk("out_instr", bus.out_instr,          ins);
        chk("out_pc4",   bus.out_pc4,            pc + 32'd4);
        chk("out_op",    32'(bus.out_op),        32'(ins >> 26));
        chk("out_rs",    32'(bus.out_rs),        (ins >> 21) & 32'h1f);
        chk("out_rt",    32'(bus.out_rt),        (ins >> 16) & 32'h1f);
        chk("out_rd",    32'(bus.out_rd),        (ins >> 11) & 32'h1f);
        chk("out_shamt", 32'(bus.out_shamt),     (ins >> 6) & 32'h1f);
        chk("out_funct", 32'(bus.out_funct),     ins & 32'h3f);
        chk("out_imm16", 32'(bus.out_imm16),     ins & 32'hffff);
        chk("out_imm26", 32'(bus.out_imm26),     ins & 32'h03ff_ffff);
        chk("misalign",  32'(bus.out_misalign),  32'(mis));
        chk("range_err", 32'(bus.out_range_err), 32'(rerr));
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit ordy, input bit fl, input bit rst_n);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.flush     = fl;
        reset         = rst_n;
    endtask

    // One clock: predict the edge from the queue model, then compare after it
    task automatic step();
        bit rdy;
        bit push;
        bit pop;
        rdy  = (reset === 1'b1) && (mq.size() < c_DEPTH);
        push = bus.in_valid && rdy && !bus.flush;
        pop  = (mq.size() != 0) && bus.out_ready && !bus.flush;
        @(posedge clk);
        if (reset !== 1'b1 || bus.flush) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back('{bus.in_pc, bus.in_instr});
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic fill_full();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3100 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b1);
            step();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset then stream
        step();
        step();
        drive(1'b1, 32'h3000, 32'h3c010001, 1'b1, 1'b0, 1'b1);
        step();
        chk("first_pc4",   bus.out_pc4, 32'h3004);
        chk("first_rt",    32'(bus.out_rt), 32'd1);
        chk("first_imm16", 32'(bus.out_imm16), 32'h0001);
        drive(1'b1, 32'h3004, 32'h34210002, 1'b1, 1'b0, 1'b1);
        step();
        chk("second_pc4",  bus.out_pc4, 32'h3008);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();

        // Fill and backpressure
        fill_full();
        chk("full_occ",   32'(bus.occupancy), 32'd2);
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        chk("drain_occ",  32'(bus.occupancy), 32'd1);
        chk("drain_pc",   bus.out_pc, 32'h3104);

        // Simultaneous push and pop across the pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h3200 + 32'(4 * i), $urandom, 1'b1, 1'b0, 1'b1);
            step();
            chk("pp_occ", 32'(bus.occupancy), 32'd1);
        end

        // Flush collision with a full queue
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();
        fill_full();
        drive(1'b1, 32'h3300, 32'hdeadbeef, 1'b1, 1'b1, 1'b1);
        step();
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_instr", bus.out_instr, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();

        // Error flags
        drive(1'b1, 32'h3002, 32'h11111111, 1'b1, 1'b0, 1'b1); step();
        chk("mis_3002", 32'(bus.out_misalign), 32'd1);
        drive(1'b1, 32'h2ffc, 32'h22222222, 1'b1, 1'b0, 1'b1); step();
        chk("rerr_2ffc", 32'(bus.out_range_err), 32'd1);
        drive(1'b1, 32'h7000, 32'h33333333, 1'b1, 1'b0, 1'b1); step();
        chk("rerr_7000", 32'(bus.out_range_err), 32'd1);
        drive(1'b1, 32'h6ffc, 32'h44444444, 1'b1, 1'b0, 1'b1); step();
        chk("ok_6ffc", 32'({bus.out_misalign, bus.out_range_err}), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step();

        // Reset mid-operation with a full, stalled queue
        fill_full();
        drive(1'b1, 32'h3400, 32'h55555555, 1'b0, 1'b1, 1'b0);
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("rst_occ", 32'(bus.occupancy), 32'd0);
        drive(1'b1, 32'h3500, 32'h66666666, 1'b0, 1'b0, 1'b1);
        step();
        chk("post_rst_instr", bus.out_instr, 32'h66666666);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            case ($urandom_range(0, 3))
                0:       pc = 32'h2ff0 + 32'($urandom_range(0, 31));
                1:       pc = 32'h6ff0 + 32'($urandom_range(0, 31));
                default: pc = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
            endcase
            drive($urandom_range(0, 3) != 0, pc, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 39) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
